// File: rtl/cpu_bus_arbiter.sv
// Two-port CPU bus arbiter: instruction fetch (A) and data (B) share one bus.
// Optional stall counters are enabled by defining CPU_BUS_ARBITER_STATS_EN.
module cpu_bus_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_pa_request,
  input  logic [31:0]           i_pa_address,
  output logic                  o_pa_ready,
  output logic [31:0]           o_pa_rdata,
  input  logic                  i_pb_request,
  input  logic                  i_pb_rw,
  input  logic [31:0]           i_pb_address,
  input  logic [31:0]           i_pb_wdata,
  input  logic [3:0]            i_pb_byte_enable,
  output logic                  o_pb_ready,
  output logic [31:0]           o_pb_rdata,
  output logic                  o_bus_request,
  output logic                  o_bus_rw,
  output logic [31:0]           o_bus_address,
  output logic [31:0]           o_bus_wdata,
  output logic [3:0]            o_bus_byte_enable,
  input  logic                  i_bus_ready,
  input  logic [31:0]           i_bus_rdata,
  output logic [STAT_WIDTH-1:0] o_stat_wait_a,
  output logic [STAT_WIDTH-1:0] o_stat_wait_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  state_e      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  // State register plus the transaction captured at grant time
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  // Next state: arbitrate in IDLE, finish a grant on the bus ready pulse
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    case (state_q)
      IDLE: begin
        if (i_pb_request &&
            (!i_pa_request || !RR_EN || !last_b_q)) begin
          state_d  = GRANT_B;
          last_b_d = 1'b1;
          rw_d     = i_pb_rw;
          addr_d   = i_pb_address;
          wdata_d  = i_pb_wdata;
          be_d     = i_pb_byte_enable;
        end else if (i_pa_request) begin
          state_d  = GRANT_A;
          last_b_d = 1'b0;
          rw_d     = 1'b0;
          addr_d   = i_pa_address;
          wdata_d  = '0;
          be_d     = 4'hF;
        end
      end
      GRANT_A, GRANT_B: begin
        if (i_bus_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: bus request while granted, ready passes straight through
  always_comb begin
    o_bus_request = 1'b0;
    o_pa_ready    = 1'b0;
    o_pb_ready    = 1'b0;
    case (state_q)
      GRANT_A: begin
        o_bus_request = 1'b1;
        o_pa_ready    = i_bus_ready;
      end
      GRANT_B: begin
        o_bus_request = 1'b1;
        o_pb_ready    = i_bus_ready;
      end
      default: ;
    endcase
    o_pa_rdata = o_pa_ready ? i_bus_rdata : '0;
    o_pb_rdata = o_pb_ready ? i_bus_rdata : '0;
  end

  assign o_bus_rw          = rw_q;
  assign o_bus_address     = addr_q;
  assign o_bus_wdata       = wdata_q;
  assign o_bus_byte_enable = be_q;

`ifdef CPU_BUS_ARBITER_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE =
    {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  logic [STAT_WIDTH-1:0] wait_a_q, wait_a_d;
  logic [STAT_WIDTH-1:0] wait_b_q, wait_b_d;

  // Stall counter registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_a_q <= '0;
      wait_b_q <= '0;
    end else begin
      wait_a_q <= wait_a_d;
      wait_b_q <= wait_b_d;
    end
  end

  // Count cycles a port is requesting but not owning the bus, saturating
  always_comb begin
    wait_a_d = wait_a_q;
    wait_b_d = wait_b_q;
    if (i_pa_request && state_q != GRANT_A && wait_a_q != '1)
      wait_a_d = wait_a_q + STAT_ONE;
    if (i_pb_request && state_q != GRANT_B && wait_b_q != '1)
      wait_b_d = wait_b_q + STAT_ONE;
  end

  assign o_stat_wait_a = wait_a_q;
  assign o_stat_wait_b = wait_b_q;
`else
  assign o_stat_wait_a = '0;
  assign o_stat_wait_b = '0;
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: ownership model plus
// directed scenarios with hand-computed expectations.
module tb_cpu_bus_arbiter;

  localparam int RR = 1;
  localparam int SW = 32;
`ifdef CPU_BUS_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pa_req = 1'b0;
  logic [31:0]   pa_addr = '0;
  logic          pa_ready;
  logic [31:0]   pa_rdata;
  logic          pb_req = 1'b0;
  logic          pb_rw = 1'b0;
  logic [31:0]   pb_addr = '0;
  logic [31:0]   pb_wdata = '0;
  logic [3:0]    pb_be = '0;
  logic          pb_ready;
  logic [31:0]   pb_rdata;
  logic          bus_req;
  logic          bus_rw;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_be;
  logic          bus_ready = 1'b0;
  logic [31:0]   bus_rdata = '0;
  logic [SW-1:0] stat_a;
  logic [SW-1:0] stat_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.ROUND_ROBIN(RR), .STAT_WIDTH(SW)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_pa_request     (pa_req),
    .i_pa_address     (pa_addr),
    .o_pa_ready       (pa_ready),
    .o_pa_rdata       (pa_rdata),
    .i_pb_request     (pb_req),
    .i_pb_rw          (pb_rw),
    .i_pb_address     (pb_addr),
    .i_pb_wdata       (pb_wdata),
    .i_pb_byte_enable (pb_be),
    .o_pb_ready       (pb_ready),
    .o_pb_rdata       (pb_rdata),
    .o_bus_request    (bus_req),
    .o_bus_rw         (bus_rw),
    .o_bus_address    (bus_addr),
    .o_bus_wdata      (bus_wdata),
    .o_bus_byte_enable(bus_be),
    .i_bus_ready      (bus_ready),
    .i_bus_rdata      (bus_rdata),
    .o_stat_wait_a    (stat_a),
    .o_stat_wait_b    (stat_b)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: who owns the bus (0 nobody, 1 A, 2 B) and what it asked for
  int            own = 0;
  int            last = 1;
  int            nxt = 0;
  logic          m_rw = 1'b0;
  logic [31:0]   m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic [3:0]    m_be = '0;
  logic [SW-1:0] m_wa = '0;
  logic [SW-1:0] m_wb = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own = 0; last = 1;
      m_rw = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
      m_wa = '0; m_wb = '0;
    end else begin
      if (STATS) begin
        if (pa_req && own != 1 && m_wa != '1) m_wa = m_wa + 1;
        if (pb_req && own != 2 && m_wb != '1) m_wb = m_wb + 1;
      end
      if (own == 0) begin
        nxt = 0;
        if (pa_req && pb_req)
          nxt = (RR == 0) ? 2 : ((last == 2) ? 1 : 2);
        else if (pa_req) nxt = 1;
        else if (pb_req) nxt = 2;
        if (nxt == 1) begin
          m_rw = 1'b0; m_addr = pa_addr; m_wdata = '0; m_be = 4'hF;
        end else if (nxt == 2) begin
          m_rw = pb_rw; m_addr = pb_addr; m_wdata = pb_wdata; m_be = pb_be;
        end
        if (nxt != 0) last = nxt;
        own = nxt;
      end else if (bus_ready) begin
        own = 0;
      end
    end
  end

  int         cnt_req = 0;
  int         cnt_pa = 0;
  int         cnt_pb = 0;
  logic [7:0] order[$];
  logic       ea, eb;

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    ea = (own == 1) && bus_ready;
    eb = (own == 2) && bus_ready;
    chk("bus_request", 64'(bus_req), 64'(own != 0));
    chk("pa_ready", 64'(pa_ready), 64'(ea));
    chk("pb_ready", 64'(pb_ready), 64'(eb));
    chk("pa_rdata", 64'(pa_rdata), 64'(ea ? bus_rdata : 32'h0));
    chk("pb_rdata", 64'(pb_rdata), 64'(eb ? bus_rdata : 32'h0));
    if (own != 0) begin
      chk("bus_rw", 64'(bus_rw), 64'(m_rw));
      chk("bus_addr", 64'(bus_addr), 64'(m_addr));
      chk("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
      chk("bus_be", 64'(bus_be), 64'(m_be));
    end
    chk("stat_a", 64'(stat_a), 64'(m_wa));
    chk("stat_b", 64'(stat_b), 64'(m_wb));
    if (bus_req) cnt_req++;
    if (pa_ready) begin cnt_pa++; order.push_back(8'h41); end
    if (pb_ready) begin cnt_pb++; order.push_back(8'h42); end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pa_req = 1'b0; pa_addr = '0;
    pb_req = 1'b0; pb_rw = 1'b0; pb_addr = '0; pb_wdata = '0; pb_be = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    step();
    rst_n = 1'b1;
    step();
    cnt_req = 0; cnt_pa = 0; cnt_pb = 0;
    order.delete();
  endtask

  string exp_o;

  initial begin
    step();
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_be", 64'(bus_be), 64'd0);
    chk("rst_stat_a", 64'(stat_a), 64'd0);

    // Lone A read, ready after three grant cycles
    do_reset();
    pa_req = 1'b1; pa_addr = 32'h0000_1000;
    step(); step(); step();
    bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("s1_pa_ready", 64'(pa_ready), 64'd1);
    chk("s1_pa_rdata", 64'(pa_rdata), 64'hDEAD_BEEF);
    step();
    pa_req = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    step(); step();
    chk("s1_req_cycles", 64'(cnt_req), 64'd3);
    chk("s1_pa_pulses", 64'(cnt_pa), 64'd1);
    chk("s1_pb_pulses", 64'(cnt_pb), 64'd0);

    // Round-robin contention, both ports held, bus always ready
    do_reset();
    pa_req = 1'b1; pa_addr = 32'h0000_0100;
    pb_req = 1'b1; pb_addr = 32'h0000_0200;
    bus_ready = 1'b1; bus_rdata = 32'hCAFE_0001;
    repeat (8) step();
    pa_req = 1'b0; pb_req = 1'b0; bus_ready = 1'b0;
    step(); step();
    exp_o = "BABA";
    chk("s2_grants", 64'(order.size()), 64'd4);
    chk("s2_req_cycles", 64'(cnt_req), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("s2_order", 64'((i < order.size()) ? order[i] : 8'h0),
          64'(exp_o[i]));

    // B write, requester changes its fields during the grant
    do_reset();
    pb_req = 1'b1; pb_rw = 1'b1; pb_addr = 32'h0000_2000;
    pb_wdata = 32'h1234_5678; pb_be = 4'b0011;
    step();
    pb_wdata = 32'hFFFF_FFFF; pb_addr = 32'h0000_BAD0; pb_be = 4'hF;
    pb_rw = 1'b0;
    chk("s3_wdata", 64'(bus_wdata), 64'h1234_5678);
    step(); step();
    bus_ready = 1'b1; bus_rdata = 32'h0000_55AA;
    #1;
    chk("s3_addr", 64'(bus_addr), 64'h2000);
    chk("s3_be", 64'(bus_be), 64'h3);
    chk("s3_rw", 64'(bus_rw), 64'd1);
    chk("s3_wdata_end", 64'(bus_wdata), 64'h1234_5678);
    chk("s3_pb_ready", 64'(pb_ready), 64'd1);
    step();
    pb_req = 1'b0; bus_ready = 1'b0;
    step();

    // Reset in the middle of an A grant
    do_reset();
    pa_req = 1'b1; pa_addr = 32'h0000_3000;
    step();
    rst_n = 1'b0;
    #1;
    chk("s4_req_drop", 64'(bus_req), 64'd0);
    bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
    #1;
    chk("s4_no_ready", 64'(pa_ready), 64'd0);
    step();
    pa_req = 1'b0; bus_ready = 1'b0;
    rst_n = 1'b1;
    step();
    chk("s4_idle", 64'(bus_req), 64'd0);
    chk("s4_pa_pulses", 64'(cnt_pa), 64'd0);

    // Ready in IDLE is ignored; A drops request mid-grant
    do_reset();
    bus_ready = 1'b1; bus_rdata = 32'h7777_7777;
    step(); step();
    chk("s5_idle_ready", 64'(cnt_pa + cnt_pb), 64'd0);
    bus_ready = 1'b0;
    pa_req = 1'b1; pa_addr = 32'h0000_4000;
    step();
    pa_req = 1'b0;
    step();
    bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
    #1;
    chk("s5_pa_ready", 64'(pa_ready), 64'd1);
    chk("s5_pa_rdata", 64'(pa_rdata), 64'h0BAD_F00D);
    step();
    bus_ready = 1'b0;
    step();
    chk("s5_pa_pulses", 64'(cnt_pa), 64'd1);

    // B holds the bus five cycles while A waits
    do_reset();
    pa_req = 1'b1; pa_addr = 32'h0000_5000;
    pb_req = 1'b1; pb_addr = 32'h0000_6000;
    step();
    repeat (4) step();
    bus_ready = 1'b1; bus_rdata = 32'h0000_0006;
    step();
    pa_req = 1'b0; pb_req = 1'b0; bus_ready = 1'b0;
    chk("s6_stat_a", 64'(stat_a), STATS ? 64'd6 : 64'd0);
    chk("s6_stat_b", 64'(stat_b), STATS ? 64'd1 : 64'd0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
